// File: rtl/loader_cmd_rx.sv
// Serial 9-bit command frame receiver: start, op[1:0], data[3:0], even parity, stop; decodes to load/set/clr strobes.
// Strobe/err one cycle after the stop bit is sampled; no backpressure, rx_valid=0 cycles stall the frame up to TIMEOUT.
module loader_cmd_rx #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic       rx_bit,
    output logic       load,
    output logic       set,
    output logic       clr,
    output logic [3:0] D,
    output logic       busy,
    output logic       err,
    output logic [7:0] frame_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, OP, DATA, PAR, STOP} state_t;

    state_t        state;
    logic [1:0]    bit_cnt;
    logic [1:0]    op;
    logic [3:0]    data;
    logic          par;
    logic [TW-1:0] idle_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            op        <= '0;
            data      <= '0;
            par       <= 1'b0;
            idle_cnt  <= '0;
            load      <= 1'b0;
            set       <= 1'b0;
            clr       <= 1'b0;
            err       <= 1'b0;
            D         <= '0;
            frame_cnt <= '0;
        end else begin
            load <= 1'b0;
            set  <= 1'b0;
            clr  <= 1'b0;
            err  <= 1'b0;
            if (state != IDLE && !rx_valid) begin
                // A stalled frame is dropped once the line stays quiet too long.
                if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    err      <= 1'b1;
                    state    <= IDLE;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else if (rx_valid) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_bit) begin
                            state   <= OP;
                            bit_cnt <= '0;
                            par     <= 1'b0;
                        end
                    end
                    OP: begin
                        op  <= {op[0], rx_bit};
                        par <= par ^ rx_bit;
                        if (bit_cnt == 2'd1) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 2'd1;
                        end
                    end
                    DATA: begin
                        data <= {data[2:0], rx_bit};
                        par  <= par ^ rx_bit;
                        if (bit_cnt == 2'd3) begin
                            bit_cnt <= '0;
                            state   <= PAR;
                        end else begin
                            bit_cnt <= bit_cnt + 2'd1;
                        end
                    end
                    PAR: begin
                        par   <= par ^ rx_bit;
                        state <= STOP;
                    end
                    STOP: begin
                        // Back to IDLE here so a start bit in the strobe cycle is taken.
                        state <= IDLE;
                        if (!rx_bit && !par) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            case (op)
                                2'b01: begin
                                    load <= 1'b1;
                                    D    <= data;
                                end
                                2'b10:   set <= 1'b1;
                                2'b11:   clr <= 1'b1;
                                default: ;
                            endcase
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_loader_cmd_rx.sv
// Directed bench for loader_cmd_rx: hand-built frames with hand-computed strobe, D and frame_cnt expectations.
module tb_loader_cmd_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic       rx_bit;
    logic       load;
    logic       set;
    logic       clr;
    logic [3:0] D;
    logic       busy;
    logic       err;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_load = 0, n_set = 0, n_clr = 0, n_err = 0;
    int last_load_cyc = 0, prev_load_cyc = 0;
    int s_load, s_set, s_clr, s_err;

    loader_cmd_rx #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
        .load(load), .set(set), .clr(clr), .D(D), .busy(busy),
        .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: pulse bookkeeping and strobe exclusivity.
    always @(negedge clk) begin
        cyc++;
        if (load) begin
            n_load++;
            prev_load_cyc = last_load_cyc;
            last_load_cyc = cyc;
        end
        if (set) n_set++;
        if (clr) n_clr++;
        if (err) n_err++;
        if (int'(load) + int'(set) + int'(clr) > 1)
            check("strobe_onehot", {29'b0, load, set, clr}, 32'h0);
    end

    // Drive one cycle mid-period, then sample just after the rising edge.
    task automatic step(input logic v, input logic b);
        @(negedge clk);
        rx_valid = v;
        rx_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] f);
        for (int i = 8; i >= 0; i--) step(1'b1, f[i]);
    endtask

    task automatic snap();
        s_load = n_load; s_set = n_set; s_clr = n_clr; s_err = n_err;
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_load", load, 0);
        check("rst_set", set, 0);
        check("rst_clr", clr, 0);
        check("rst_err", err, 0);
        check("rst_D", D, 0);
        check("rst_busy", busy, 0);
        check("rst_fcnt", frame_cnt, 0);
        reset = 1'b0;

        // Valid zero in IDLE is not a start bit.
        step(1'b1, 1'b0);
        check("idle_zero_busy", busy, 0);
        check("idle_zero_err", err, 0);

        // Load 1010
        step(1'b1, 1'b1);
        check("start_busy", busy, 1);
        for (int i = 7; i >= 0; i--) step(1'b1, 1'(9'b1_01_1010_1_0 >> i));
        check("ld_load", load, 1);
        check("ld_D", D, 4'b1010);
        check("ld_fcnt", frame_cnt, 1);
        check("ld_err", err, 0);
        check("ld_busy", busy, 0);
        step(1'b0, 1'b0);
        check("ld_load_gone", load, 0);

        // Set
        send_frame(9'b1_10_0000_1_0);
        check("set_set", set, 1);
        check("set_D", D, 4'b1010);
        check("set_fcnt", frame_cnt, 2);
        step(1'b0, 1'b0);
        check("set_gone", set, 0);

        // Parity flipped
        snap();
        send_frame(9'b1_01_1010_0_0);
        check("par_err", err, 1);
        check("par_load", load, 0);
        check("par_D", D, 4'b1010);
        check("par_fcnt", frame_cnt, 2);
        step(1'b0, 1'b0);
        check("par_err_gone", err, 0);
        check("par_one_err", n_err - s_err, 1);

        // Stop bit 1
        send_frame(9'b1_01_1010_1_1);
        check("stop_err", err, 1);
        check("stop_load", load, 0);
        check("stop_fcnt", frame_cnt, 2);

        // Timeout after three bits
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        step(1'b0, 1'b0);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        step(1'b0, 1'b0);
        check("to_err_gone", err, 0);
        send_frame(9'b1_11_0000_0_0);
        check("clr_clr", clr, 1);
        check("clr_D", D, 4'b1010);
        check("clr_fcnt", frame_cnt, 3);
        step(1'b0, 1'b0);
        check("clr_gone", clr, 0);

        // Short gaps mid-frame only stall it: load 0011
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
        check("gap_load", load, 1);
        check("gap_D", D, 4'b0011);
        check("gap_fcnt", frame_cnt, 4);

        // Back-to-back loads 0110 then 0111
        step(1'b0, 1'b0);
        send_frame(9'b1_01_0110_1_0);
        check("b2b_load1", load, 1);
        check("b2b_D1", D, 4'b0110);
        send_frame(9'b1_01_0111_0_0);
        check("b2b_load2", load, 1);
        check("b2b_D2", D, 4'b0111);
        check("b2b_fcnt", frame_cnt, 6);
        step(1'b0, 1'b0);
        check("b2b_spacing", last_load_cyc - prev_load_cyc, 9);

        // Reset at the fifth bit of a load frame
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        snap();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b1; rx_bit = 1'b0;
        @(posedge clk);
        #1;
        check("rm_busy", busy, 0);
        check("rm_D", D, 0);
        check("rm_fcnt", frame_cnt, 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        check("rm_no_load", n_load - s_load, 0);
        check("rm_no_err", n_err - s_err, 0);
        check("rm_busy_after", busy, 0);

        // Nop frames: counted, no strobes, counter wraps
        send_frame(9'b1_00_0000_0_0);
        check("nop_fcnt", frame_cnt, 1);
        check("nop_err", err, 0);
        snap();
        for (int i = 0; i < 254; i++) send_frame(9'b1_00_0000_0_0);
        check("nop_fcnt255", frame_cnt, 255);
        send_frame(9'b1_00_0000_0_0);
        check("nop_wrap", frame_cnt, 0);
        step(1'b0, 1'b0);
        check("nop_no_strobe", (n_load - s_load) + (n_set - s_set) + (n_clr - s_clr), 0);
        check("nop_no_err", n_err - s_err, 0);
        check("nop_D", D, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/loader_cmd_rx.md
LOADER_CMD_RX -- requirements
Module: loader_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning the number of consecutive idle (rx_valid=0) cycles tolerated mid-frame before abort.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_valid  input  1  rx_bit is meaningful this cycle; cycles with rx_valid=0 are ignored, apart from the timeout count.
REQ-005 SHALL have port rx_bit  input  1  serial command bit.
REQ-006 SHALL have port load  output  1  one-cycle strobe; downstream register captures D.
REQ-007 SHALL have port set  output  1  one-cycle strobe; downstream register goes to all ones.
REQ-008 SHALL have port clr  output  1  one-cycle strobe; downstream register goes to zero; drives the downstream reset pin.
REQ-009 SHALL have port D  output  4  data from the last accepted load command.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port err  output  1  one-cycle pulse when a frame is discarded.
REQ-012 SHALL have port frame_cnt  output  8  count of accepted frames, including nop frames.

Function
REQ-013 SHALL use a 9-bit frame, in sampling order: start (must be 1), op[1:0] MSB first, data[3:0] MSB first, parity, stop (must be 0).
REQ-014 SHALL treat parity as even parity over op and data and the parity bit: the XOR of all 7 bits is 0.
REQ-015 SHALL implement FSM states IDLE, OP, DATA, PAR, STOP, with a bit counter inside OP and DATA.
REQ-016 SHALL, in IDLE, move to OP only on rx_valid=1 and rx_bit=1; rx_valid=1 with rx_bit=0 SHALL stay in IDLE with no error.
REQ-017 SHALL advance one bit position only on cycles with rx_valid=1.
REQ-018 SHALL accept the frame when STOP samples rx_bit=0 and parity is good.
REQ-019 SHALL, on an accepted frame, decode op in the cycle after the stop bit is sampled: 00 nop (no strobe), 01 load, 10 set, 11 clr.
REQ-020 SHALL hold load, set and clr for exactly one cycle, and SHALL never assert more than one of them in the same cycle.
REQ-021 SHALL update D only on an accepted load command, in the same cycle that load is high; set, clr and nop frames SHALL leave D unchanged.
REQ-022 SHALL, on a frame with a parity error or stop bit 1, pulse err the cycle after stop, assert no strobe, leave D and frame_cnt unchanged, and return to IDLE.
REQ-023 SHALL count consecutive rx_valid=0 cycles while not in IDLE, and clear the count on any rx_valid=1 cycle.
REQ-024 SHALL, when that count reaches TIMEOUT, pulse err the next cycle, return to IDLE and discard the partial frame.
REQ-025 SHALL increment frame_cnt by 1 for each accepted frame, in the strobe cycle, wrapping from 255 to 0.
REQ-026 SHALL return the FSM to IDLE at the edge that samples the stop bit, so a start bit presented in the strobe/err cycle is accepted back-to-back.
REQ-027 SHALL deassert busy in the strobe/err cycle.

Reset
REQ-028 SHALL, while reset=1 at a rising edge, force: FSM IDLE, counters 0, load=set=clr=err=0, D=4'b0000, busy=0, frame_cnt=0.
REQ-029 SHALL give reset priority over all frame activity, including a strobe that would have issued that cycle; a reset mid-frame SHALL discard the frame without err.

Verification
REQ-030 SHALL cover: rx_bit 1,0,1,1,0,1,0,1,0 on consecutive valid cycles -> load=1 for one cycle, D=4'b1010, frame_cnt=1, err=0.
REQ-031 SHALL cover: frame 1,1,0,0,0,0,0,1,0 after the load frame -> set=1 for one cycle, D stays 4'b1010, frame_cnt=2.
REQ-032 SHALL cover: load frame with the parity bit flipped (1,0,1,1,0,1,0,0,0) -> err=1 for one cycle, no strobe, D unchanged, frame_cnt unchanged.
REQ-033 SHALL cover: three frame bits, then rx_valid=0 for 8 cycles -> err pulse, busy=0; a following clr frame 1,1,1,0,0,0,0,0,0 -> clr=1 for one cycle.
REQ-034 SHALL cover: reset=1 asserted at the fifth bit of a load frame -> no strobe, no err, D=0, frame_cnt=0, busy=0.
REQ-035 SHALL cover: two load frames sent back-to-back with no gap (data 0110, then 0111) -> two load pulses 9 cycles apart, D=0110 then 0111.
